instr_mem_ctrl: RTL and testbench
=================================

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, extra SRAM wait cycles per access; access length L = WAIT_CYCLES+1 (legal 1..6, so L = 2..7).
REQ-002 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-003 RST  in  1  asynchronous, active-low reset.
REQ-004 pc_i  in  16  fetch address from the fetch stage, valid every cycle.
REQ-005 instr_o  out  16  instruction for pc_i; NOP 16'h0800 when not a hit.
REQ-006 stall_pc_o  out  1  high while instr_o does not hold the word at pc_i.
REQ-007 mem_rd_i / mem_wr_i  in  1 each  data-stage read/write request, level, held until ack.
REQ-008 mem_addr_i  in  16; mem_wdata_i  in  16  data-stage address and write data.
REQ-009 mem_rdata_o  out  16  read data; mem_ack_o  out  1  one-cycle completion pulse.
REQ-010 ram_addr_o  out  18 = {2'b00, address}; ram_data_o  out  16; ram_data_i  in  16; ram_data_oe_o  out  1  tristate enable for the board pad.
REQ-011 ram_ce_n_o / ram_oe_n_o / ram_we_n_o  out  1 each  active-low SRAM strobes.

Function
REQ-012 One-entry fetch buffer: instr_reg[15:0], tag[15:0], valid; hit = valid && tag == pc_i (combinational).
REQ-013 instr_o = hit ? instr_reg : 16'h0800; stall_pc_o = !hit (combinational).
REQ-014 States: IDLE, FETCH, DRD, DWR, DWR_REC; wait counter 3 bits.
REQ-015 IDLE priority: mem_wr_i -> DWR; else mem_rd_i -> DRD; else !hit -> FETCH, latching pc_i as the access address; else stay.
REQ-016 Simultaneous mem_rd_i and mem_wr_i: treated as a write, no read performed.
REQ-017 An access in progress always completes; new requests are sampled only in IDLE.
REQ-018 FETCH: ce_n=0, oe_n=0, we_n=1, data_oe=0 for L cycles; on the L-th posedge capture ram_data_i -> instr_reg, access address -> tag, valid=1, return to IDLE.
REQ-019 A pc_i change during FETCH does not abort it; the stale word is buffered, hit stays low, and a new fetch starts from IDLE.
REQ-020 DRD: same strobes as FETCH for L cycles; at completion ram_data_i -> mem_rdata_o, mem_ack_o=1 for exactly the next cycle, -> IDLE.
REQ-021 mem_rdata_o holds its value until the next read completes.
REQ-022 DWR: ce_n=0, oe_n=1, we_n=0, data_oe=1, ram_data_o=mem_wdata_i for L cycles, -> DWR_REC.
REQ-023 DWR_REC: one cycle with we_n=1, data_oe=1 and data still driven (hold time); mem_ack_o=1 in this cycle; -> IDLE.
REQ-024 If the write address equals tag, valid clears at DWR entry, forcing a refetch.
REQ-025 IDLE strobes: ce_n=1, oe_n=1, we_n=1, data_oe=0; ram_addr_o holds the last address.
REQ-026 Requesters must drop mem_rd_i/mem_wr_i in the ack cycle; a request still high in IDLE after ack is a new access.

Reset
REQ-027 While RST=0: state IDLE, counter 0, valid=0, instr_reg=0, tag=0, mem_rdata_o=0, mem_ack_o=0, all strobes high, data_oe=0, ram_addr_o=0, ram_data_o=0.
REQ-028 Reset mid-access aborts the access immediately (asynchronously); no partial data is captured and no ack is issued.
REQ-029 After reset, stall_pc_o=1 until the first fetch completes.

Verification (WAIT_CYCLES=1, L=2)
REQ-030 Release reset, pc_i=0, SRAM[0]=16'h4801 -> stall_pc_o high 2 cycles after release, then instr_o=16'h4801, stall_pc_o=0.
REQ-031 pc_i 0->1, SRAM[1]=16'h6A05 -> instr_o=16'h0800 and stall high for 2 cycles, then instr_o=16'h6A05.
REQ-032 mem_rd_i=1, addr 16'h8000, asserted during the 1st FETCH cycle, SRAM=16'h1234 -> fetch completes first; DRD 2 cycles; mem_ack_o one pulse with mem_rdata_o=16'h1234; then fetch resumes.
REQ-033 mem_wr_i=1, addr equal to tag, data 16'hBEEF -> we_n low 2 cycles, 1 recovery cycle with ack; stall rises; refetch gives instr_o=16'hBEEF.
REQ-034 RST low during the 1st DWR cycle -> we_n=1 and data_oe=0 immediately; no ack; SRAM contents are not checked.
REQ-035 mem_rd_i=mem_wr_i=1 together -> write sequence only; exactly one ack; mem_rdata_o unchanged.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: one-entry fetch buffer plus arbiter sharing a single async SRAM between fetch and data accesses
module instr_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] pc_i,
    output logic [15:0] instr_o,
    output logic        stall_pc_o,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [15:0] mem_addr_i,
    input  logic [15:0] mem_wdata_i,
    output logic [15:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic [17:0] ram_addr_o,
    output logic [15:0] ram_data_o,
    input  logic [15:0] ram_data_i,
    output logic        ram_data_oe_o,
    output logic        ram_ce_n_o,
    output logic        ram_oe_n_o,
    output logic        ram_we_n_o
);
    typedef enum logic [2:0] {IDLE, FETCH, DRD, DWR, DWR_REC} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] tag_q, tag_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        hit, done;
    assign hit           = valid_q && tag_q == pc_i;
    assign done          = cnt_q == 3'(WAIT_CYCLES);
    assign instr_o       = hit ? instr_q : 16'h0800;
    assign stall_pc_o    = !hit;
    assign mem_rdata_o   = rdata_q;
    assign mem_ack_o     = ack_q;
    assign ram_addr_o    = {2'b00, addr_q};
    assign ram_data_o    = data_q;
    assign ram_ce_n_o    = state_q == IDLE;
    assign ram_oe_n_o    = !(state_q == FETCH || state_q == DRD);
    assign ram_we_n_o    = state_q != DWR;
    assign ram_data_oe_o = state_q == DWR || state_q == DWR_REC;
    // next-state: requests are only accepted in IDLE; every started access runs L cycles to completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        instr_d = instr_q;
        tag_d   = tag_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                if (mem_wr_i) begin
                    state_d = DWR;
                    addr_d  = mem_addr_i;
                    data_d  = mem_wdata_i;
                    valid_d = valid_q && mem_addr_i != tag_q;
                end else if (mem_rd_i) begin
                    state_d = DRD;
                    addr_d  = mem_addr_i;
                end else if (!hit) begin
                    state_d = FETCH;
                    addr_d  = pc_i;
                end
            end
            FETCH: begin
                cnt_d = done ? 3'd0 : cnt_q + 3'd1;
                if (done) begin
                    state_d = IDLE;
                    instr_d = ram_data_i;
                    tag_d   = addr_q;
                    valid_d = 1'b1;
                end
            end
            DRD: begin
                cnt_d = done ? 3'd0 : cnt_q + 3'd1;
                if (done) begin
                    state_d = IDLE;
                    rdata_d = ram_data_i;
                    ack_d   = 1'b1;
                end
            end
            DWR: begin
                cnt_d   = done ? 3'd0 : cnt_q + 3'd1;
                state_d = done ? DWR_REC : DWR;
                ack_d   = done;
            end
            DWR_REC: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state register; reset aborts any access at once so strobes release without waiting for a clock
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            instr_q <= 16'h0000;
            tag_q   <= 16'h0000;
            rdata_q <= 16'h0000;
            ack_q   <= 1'b0;
            addr_q  <= 16'h0000;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            tag_q   <= tag_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: directed checks of fetch, data read, write-invalidate and reset abort with an SRAM model
module tb_instr_mem_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] pc_i = 16'h0000;
    logic [15:0] instr_o;
    logic        stall_pc_o;
    logic        mem_rd_i = 1'b0;
    logic        mem_wr_i = 1'b0;
    logic [15:0] mem_addr_i = 16'h0000;
    logic [15:0] mem_wdata_i = 16'h0000;
    logic [15:0] mem_rdata_o;
    logic        mem_ack_o;
    logic [17:0] ram_addr_o;
    logic [15:0] ram_data_o;
    logic [15:0] ram_data_i;
    logic        ram_data_oe_o;
    logic        ram_ce_n_o;
    logic        ram_oe_n_o;
    logic        ram_we_n_o;
    logic [15:0] sram [0:65535];
    int          checks = 0;
    int          errors = 0;

    instr_mem_ctrl #(.WAIT_CYCLES(1)) dut (
        .CLK(CLK), .RST(RST), .pc_i(pc_i), .instr_o(instr_o), .stall_pc_o(stall_pc_o),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_data_i(ram_data_i), .ram_data_oe_o(ram_data_oe_o), .ram_ce_n_o(ram_ce_n_o),
        .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o)
    );

    always #5 CLK = ~CLK;

    assign ram_data_i = sram[ram_addr_o[15:0]];

    // SRAM model: preload a few words, then latch writes while ce and we are both low
    always @(posedge CLK) begin
        if (!ram_ce_n_o && !ram_we_n_o) sram[ram_addr_o[15:0]] = ram_data_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 16'h0000;
        sram[0]       = 16'h4801;
        sram[1]       = 16'h6A05;
        sram[2]       = 16'h7777;
        sram[3]       = 16'h3333;
        sram[16'h8000] = 16'h1234;
        #12;
        check("rst_stall", 32'(stall_pc_o), 1);
        check("rst_instr", 32'(instr_o), 32'h0800);
        check("rst_ack", 32'(mem_ack_o), 0);
        check("rst_strobes", {28'd0, ram_ce_n_o, ram_oe_n_o, ram_we_n_o, ram_data_oe_o}, 32'hE);
        check("rst_addr", 32'(ram_addr_o), 0);
        check("rst_rdata", 32'(mem_rdata_o), 0);
        check("rst_wdata", 32'(ram_data_o), 0);
        @(negedge CLK);
        RST = 1'b1;
        step(1);
        check("f0_c1_stall", 32'(stall_pc_o), 1);
        check("f0_c1_strobes", {29'd0, ram_ce_n_o, ram_oe_n_o, ram_we_n_o}, 32'h1);
        step(1);
        check("f0_c2_stall", 32'(stall_pc_o), 1);
        step(1);
        check("f0_stall", 32'(stall_pc_o), 0);
        check("f0_instr", 32'(instr_o), 32'h4801);
        check("f0_idle_ce", 32'(ram_ce_n_o), 1);
        pc_i = 16'h0001;
        #1;
        check("pc1_instr_nop", 32'(instr_o), 32'h0800);
        step(2);
        check("pc1_c1_stall", 32'(stall_pc_o), 1);
        check("pc1_c1_instr", 32'(instr_o), 32'h0800);
        check("pc1_addr", 32'(ram_addr_o), 1);
        step(1);
        check("pc1_instr", 32'(instr_o), 32'h6A05);
        check("pc1_stall", 32'(stall_pc_o), 0);
        pc_i = 16'h0002;
        step(1);
        mem_rd_i   = 1'b1;
        mem_addr_i = 16'h8000;
        step(1);
        pc_i = 16'h0003;
        check("rd_wait_fetch", 32'(ram_addr_o), 2);
        step(1);
        check("stale_stall", 32'(stall_pc_o), 1);
        check("stale_instr", 32'(instr_o), 32'h0800);
        step(1);
        check("drd_addr", 32'(ram_addr_o), 32'h8000);
        check("drd_oe", 32'(ram_oe_n_o), 0);
        check("drd_ack0", 32'(mem_ack_o), 0);
        step(1);
        check("drd_c2_ack0", 32'(mem_ack_o), 0);
        step(1);
        check("drd_ack", 32'(mem_ack_o), 1);
        check("drd_rdata", 32'(mem_rdata_o), 32'h1234);
        mem_rd_i = 1'b0;
        step(1);
        check("drd_ack_pulse", 32'(mem_ack_o), 0);
        check("refetch_addr", 32'(ram_addr_o), 3);
        step(2);
        check("pc3_instr", 32'(instr_o), 32'h3333);
        check("pc3_stall", 32'(stall_pc_o), 0);
        mem_wr_i    = 1'b1;
        mem_addr_i  = 16'h0003;
        mem_wdata_i = 16'hBEEF;
        step(1);
        check("dwr_we", 32'(ram_we_n_o), 0);
        check("dwr_doe", 32'(ram_data_oe_o), 1);
        check("dwr_data", 32'(ram_data_o), 32'hBEEF);
        check("dwr_oe_n", 32'(ram_oe_n_o), 1);
        check("dwr_inval_stall", 32'(stall_pc_o), 1);
        step(1);
        check("dwr_c2_we", 32'(ram_we_n_o), 0);
        check("dwr_c2_ack0", 32'(mem_ack_o), 0);
        step(1);
        check("rec_we", 32'(ram_we_n_o), 1);
        check("rec_doe", 32'(ram_data_oe_o), 1);
        check("rec_data", 32'(ram_data_o), 32'hBEEF);
        check("rec_ack", 32'(mem_ack_o), 1);
        mem_wr_i = 1'b0;
        step(1);
        check("rec_ack_pulse", 32'(mem_ack_o), 0);
        check("rec_stall", 32'(stall_pc_o), 1);
        step(3);
        check("beef_instr", 32'(instr_o), 32'hBEEF);
        check("beef_stall", 32'(stall_pc_o), 0);
        mem_rd_i    = 1'b1;
        mem_wr_i    = 1'b1;
        mem_addr_i  = 16'h0010;
        mem_wdata_i = 16'hCAFE;
        step(1);
        check("both_we", 32'(ram_we_n_o), 0);
        check("both_ack0", 32'(mem_ack_o), 0);
        step(1);
        check("both_c2_ack0", 32'(mem_ack_o), 0);
        step(1);
        check("both_ack", 32'(mem_ack_o), 1);
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
        step(1);
        check("both_ack_end", 32'(mem_ack_o), 0);
        check("both_rdata", 32'(mem_rdata_o), 32'h1234);
        check("both_written", 32'(sram[16]), 32'hCAFE);
        step(2);
        check("both_no_ack", 32'(mem_ack_o), 0);
        check("both_keep_hit", 32'(stall_pc_o), 0);
        mem_wr_i    = 1'b1;
        mem_addr_i  = 16'h0005;
        mem_wdata_i = 16'hAAAA;
        step(1);
        check("abort_pre_we", 32'(ram_we_n_o), 0);
        #2;
        RST = 1'b0;
        #1;
        check("abort_we", 32'(ram_we_n_o), 1);
        check("abort_doe", 32'(ram_data_oe_o), 0);
        check("abort_ce", 32'(ram_ce_n_o), 1);
        check("abort_stall", 32'(stall_pc_o), 1);
        check("abort_addr", 32'(ram_addr_o), 0);
        step(1);
        check("abort_no_ack", 32'(mem_ack_o), 0);
        mem_wr_i = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        step(2);
        check("post_rst_stall", 32'(stall_pc_o), 1);
        step(1);
        check("post_rst_instr", 32'(instr_o), 32'hBEEF);
        check("post_rst_ack", 32'(mem_ack_o), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
